// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants and state encodings for the PS/2 key tracker.
//   PS2_BREAK / PS2_EXT : break and extended-prefix scan bytes
//   rx_state_t          : frame receiver states
//   trk_state_t         : make/break tracker states
package ps2_pkg;
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  typedef enum logic {
    RX_IDLE  = 1'b0,
    RX_SHIFT = 1'b1
  } rx_state_t;

  typedef enum logic [1:0] {
    TRK_IDLE = 2'd0,
    TRK_HELD = 2'd1,
    TRK_BRK  = 2'd2
  } trk_state_t;
endpackage

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 frame receiver.
//   Synchronises the pad clock/data, detects falling edges of the PS/2
//   clock and shifts in one 11-bit frame (start, 8 data LSB first, odd
//   parity, stop). A good frame pulses o_byte_vld for one cycle with
//   o_byte; a bad frame pulses o_err instead. A frame stalled for
//   TIMEOUT_CYC cycles is silently discarded.
//   Build option: PS2_PARITY_CHK_EN enables the odd-parity check; without
//   it the parity bit is ignored and only the stop bit is checked.
// Ports:
//   clk, rst_n       system clock, async active-low reset
//   i_ps2_clk/data   raw pad inputs (asynchronous to clk)
//   o_byte_vld       one-cycle pulse, o_byte valid
//   o_byte           received data byte
//   o_err            one-cycle pulse on a dropped (bad) frame
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic       o_byte_vld,
  output logic [7:0] o_byte,
  output logic       o_err
);
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [2:0]      r_clk_sync;  // [1:0] synchroniser, [2] edge history
  logic [1:0]      r_dat_sync;
  logic            r_fall;
  rx_state_t       r_state;
  logic [3:0]      r_bit_cnt;
  logic [7:0]      r_shift;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_byte_vld;
  logic [7:0]      r_byte;
  logic            r_err;
`ifdef PS2_PARITY_CHK_EN
  logic            r_par;
`endif

  logic w_dat;
  logic w_frame_ok;

  assign w_dat = r_dat_sync[1];

  // Evaluated while the stop bit is being sampled (w_dat is the stop bit).
`ifdef PS2_PARITY_CHK_EN
  assign w_frame_ok = w_dat & (^{r_par, r_shift});
`else
  assign w_frame_ok = w_dat;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Idle PS/2 lines are high; resetting the chain high prevents a
      // phantom falling edge right after reset.
      r_clk_sync <= 3'b111;
      r_dat_sync <= 2'b11;
      r_fall     <= 1'b0;
      r_state    <= RX_IDLE;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_to_cnt   <= '0;
      r_byte_vld <= 1'b0;
      r_byte     <= '0;
      r_err      <= 1'b0;
`ifdef PS2_PARITY_CHK_EN
      r_par      <= 1'b0;
`endif
    end else begin
      r_clk_sync <= {r_clk_sync[1:0], i_ps2_clk};
      r_dat_sync <= {r_dat_sync[0], i_ps2_data};
      // Registered edge strobe: asserted 3 clk after the pad edge.
      r_fall     <= r_clk_sync[2] & ~r_clk_sync[1];
      r_byte_vld <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          r_to_cnt <= '0;
          if (r_fall && !w_dat) begin
            r_state   <= RX_SHIFT;
            r_bit_cnt <= '0;
          end
        end
        RX_SHIFT: begin
          if (r_fall) begin
            r_to_cnt  <= '0;
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (r_bit_cnt < 4'd8) begin
              r_shift <= {w_dat, r_shift[7:1]};
            end else if (r_bit_cnt == 4'd9) begin
              r_state <= RX_IDLE;
              if (w_frame_ok) begin
                r_byte_vld <= 1'b1;
                r_byte     <= r_shift;
              end else begin
                r_err <= 1'b1;
              end
            end
`ifdef PS2_PARITY_CHK_EN
            else begin
              r_par <= w_dat;
            end
`endif
          end else if (r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
            r_state <= RX_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

  assign o_byte_vld = r_byte_vld;
  assign o_byte     = r_byte;
  assign o_err      = r_err;
endmodule

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: PS/2 keyboard to seven-segment digit driver.
//   Tracks make/break scan codes, shows the held key's code on two digits
//   (blanked when nothing is held) and a modulo-256 press counter on two
//   always-lit digits.
//   Build option: PS2_PARITY_CHK_EN (passed through to ps2_rx) enables
//   odd-parity checking of received frames.
// Ports:
//   clk, rst_n   system clock, async active-low reset
//   ps2_clk/data raw PS/2 pad inputs
//   code_nib     held scan code ([7:4] high digit, [3:0] low digit)
//   code_clr     blank request for the scan-code digits
//   cnt_nib      press count ([7:4] high digit, [3:0] low digit)
//   frame_err    sticky frame error, cleared only by reset
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50000,
  parameter int CNT_W       = 8    // fixed by the two-digit display
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  output logic [7:0]       code_nib,
  output logic             code_clr,
  output logic [CNT_W-1:0] cnt_nib,
  output logic             frame_err
);
  logic       w_byte_vld;
  logic [7:0] w_byte;
  logic       w_err;

  ps2_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_ps2_clk (ps2_clk),
    .i_ps2_data(ps2_data),
    .o_byte_vld(w_byte_vld),
    .o_byte    (w_byte),
    .o_err     (w_err)
  );

  trk_state_t       r_state;
  trk_state_t       r_ret;
  logic [7:0]       r_held;
  logic             r_held_vld;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= TRK_IDLE;
      r_ret      <= TRK_IDLE;
      r_held     <= '0;
      r_held_vld <= 1'b0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_err) r_err <= 1'b1;
      // The extended prefix carries no key identity; the following byte
      // is tracked like an ordinary code.
      if (w_byte_vld && w_byte != PS2_EXT) begin
        case (r_state)
          TRK_IDLE: begin
            if (w_byte == PS2_BREAK) begin
              r_state <= TRK_BRK;
              r_ret   <= TRK_IDLE;
            end else begin
              r_held     <= w_byte;
              r_held_vld <= 1'b1;
              r_cnt      <= r_cnt + 1'b1;
              r_state    <= TRK_HELD;
            end
          end
          TRK_HELD: begin
            if (w_byte == PS2_BREAK) begin
              r_state <= TRK_BRK;
              r_ret   <= TRK_HELD;
            end else if (w_byte != r_held) begin
              // Typematic repeats of the held code fall through unchanged.
              r_held <= w_byte;
              r_cnt  <= r_cnt + 1'b1;
            end
          end
          TRK_BRK: begin
            if (r_held_vld && w_byte == r_held) begin
              r_held_vld <= 1'b0;
              r_state    <= TRK_IDLE;
            end else begin
              // Release of a key that is not the displayed one.
              r_state <= r_ret;
            end
          end
          default: r_state <= TRK_IDLE;
        endcase
      end
    end
  end

  assign code_nib  = r_held;
  assign code_clr  = ~r_held_vld;
  assign cnt_nib   = r_cnt;
  assign frame_err = r_err;
endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb_ps2_key_tracker: directed self-checking bench for ps2_key_tracker.
// The PS/2 clock is run much faster than a real keyboard (3 clk per half
// period) and the timeout is scaled down to keep the run short.
module tb_ps2_key_tracker;
  localparam int H     = 3;     // PS/2 half-period in clk cycles
  localparam int GAP   = 8;     // idle clk between frames
  localparam int TO    = 2000;  // scaled receive timeout

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] code_nib;
  logic       code_clr;
  logic [7:0] cnt_nib;
  logic       frame_err;

  int n_tests = 0;
  int n_fail  = 0;

  ps2_key_tracker #(.TIMEOUT_CYC(TO), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .code_nib (code_nib),
    .code_clr (code_clr),
    .cnt_nib  (cnt_nib),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_flip,
                            input logic stop_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ par_flip);
    send_bit(stop_b);
    ps2_data = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (code_clr !== 1'b1) begin n_fail++; $display("FAIL reset_clr got %b exp 1", code_clr); end
    n_tests++; if (code_nib !== 8'h00) begin n_fail++; $display("FAIL reset_code got %h exp 00", code_nib); end
    n_tests++; if (cnt_nib !== 8'h00) begin n_fail++; $display("FAIL reset_cnt got %h exp 00", cnt_nib); end
    n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", frame_err); end
  endtask

  task automatic test_press_release();
    do_reset();
    send(8'h1C);
    n_tests++; if (code_nib !== 8'h1C) begin n_fail++; $display("FAIL press_code got %h exp 1c", code_nib); end
    n_tests++; if (code_clr !== 1'b0) begin n_fail++; $display("FAIL press_clr got %b exp 0", code_clr); end
    n_tests++; if (cnt_nib !== 8'h01) begin n_fail++; $display("FAIL press_cnt got %h exp 01", cnt_nib); end
    send(8'hF0);
    n_tests++; if (code_clr !== 1'b0) begin n_fail++; $display("FAIL brk_pending_clr got %b exp 0", code_clr); end
    send(8'h1C);
    n_tests++; if (code_clr !== 1'b1) begin n_fail++; $display("FAIL release_clr got %b exp 1", code_clr); end
    n_tests++; if (cnt_nib !== 8'h01) begin n_fail++; $display("FAIL release_cnt got %h exp 01", cnt_nib); end
  endtask

  task automatic test_typematic();
    do_reset();
    repeat (5) send(8'h1C);
    n_tests++; if (cnt_nib !== 8'h01) begin n_fail++; $display("FAIL typematic_cnt got %h exp 01", cnt_nib); end
    send(8'h32);
    n_tests++; if (code_nib !== 8'h32) begin n_fail++; $display("FAIL change_code got %h exp 32", code_nib); end
    n_tests++; if (cnt_nib !== 8'h02) begin n_fail++; $display("FAIL change_cnt got %h exp 02", cnt_nib); end
    send(8'hF0); send(8'h1C);
    n_tests++; if (code_nib !== 8'h32) begin n_fail++; $display("FAIL stale_rel_code got %h exp 32", code_nib); end
    n_tests++; if (code_clr !== 1'b0) begin n_fail++; $display("FAIL stale_rel_clr got %b exp 0", code_clr); end
    // Held state must survive the unrelated release: a new key still counts.
    send(8'h33);
    n_tests++; if (cnt_nib !== 8'h03) begin n_fail++; $display("FAIL after_stale_cnt got %h exp 03", cnt_nib); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 256; i++) begin
      send(8'h23); send(8'hF0); send(8'h23);
    end
    n_tests++; if (cnt_nib !== 8'h00) begin n_fail++; $display("FAIL wrap_cnt got %h exp 00", cnt_nib); end
    n_tests++; if (code_clr !== 1'b1) begin n_fail++; $display("FAIL wrap_clr got %b exp 1", code_clr); end
    send(8'h23); send(8'hF0); send(8'h23);
    n_tests++; if (cnt_nib !== 8'h01) begin n_fail++; $display("FAIL wrap_plus1_cnt got %h exp 01", cnt_nib); end
  endtask

  task automatic test_bad_parity();
    do_reset();
    send_frame(8'h1C, 1'b1, 1'b1);
`ifdef PS2_PARITY_CHK_EN
    n_tests++; if (code_nib !== 8'h00) begin n_fail++; $display("FAIL badpar_code got %h exp 00", code_nib); end
    n_tests++; if (code_clr !== 1'b1) begin n_fail++; $display("FAIL badpar_clr got %b exp 1", code_clr); end
    n_tests++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL badpar_err got %b exp 1", frame_err); end
`else
    n_tests++; if (code_nib !== 8'h1C) begin n_fail++; $display("FAIL badpar_code got %h exp 1c", code_nib); end
    n_tests++; if (code_clr !== 1'b0) begin n_fail++; $display("FAIL badpar_clr got %b exp 0", code_clr); end
    n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL badpar_err got %b exp 0", frame_err); end
`endif
  endtask

  task automatic test_bad_stop();
    do_reset();
    send_frame(8'h45, 1'b0, 1'b0);
    n_tests++; if (code_clr !== 1'b1) begin n_fail++; $display("FAIL badstop_clr got %b exp 1", code_clr); end
    n_tests++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL badstop_err got %b exp 1", frame_err); end
    // Error is sticky and the next clean frame still decodes.
    send(8'h45);
    n_tests++; if (code_nib !== 8'h45) begin n_fail++; $display("FAIL after_badstop_code got %h exp 45", code_nib); end
    n_tests++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL sticky_err got %b exp 1", frame_err); end
  endtask

  task automatic test_timeout_ext();
    do_reset();
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    ps2_data = 1'b1;
    repeat (TO + 1000) @(negedge clk);
    send(8'h1C);
    n_tests++; if (code_nib !== 8'h1C) begin n_fail++; $display("FAIL timeout_code got %h exp 1c", code_nib); end
    n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL timeout_err got %b exp 0", frame_err); end
    n_tests++; if (cnt_nib !== 8'h01) begin n_fail++; $display("FAIL timeout_cnt got %h exp 01", cnt_nib); end
    send(8'hE0); send(8'h75);
    n_tests++; if (code_nib !== 8'h75) begin n_fail++; $display("FAIL ext_code got %h exp 75", code_nib); end
    n_tests++; if (cnt_nib !== 8'h02) begin n_fail++; $display("FAIL ext_cnt got %h exp 02", cnt_nib); end
    send(8'hE0); send(8'hF0); send(8'hE0); send(8'h75);
    n_tests++; if (code_clr !== 1'b1) begin n_fail++; $display("FAIL ext_release_clr got %b exp 1", code_clr); end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    do_reset();
    send(8'h2B);
    n_tests++; if (code_nib !== 8'h2B) begin n_fail++; $display("FAIL midreset_code got %h exp 2b", code_nib); end
    n_tests++; if (cnt_nib !== 8'h01) begin n_fail++; $display("FAIL midreset_cnt got %h exp 01", cnt_nib); end
  endtask

  task automatic test_latency();
    logic [7:0] b;
    do_reset();
    b = 8'h5A;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~^b);
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_tests++; if (code_nib !== 8'h00) begin n_fail++; $display("FAIL latency_early got %h exp 00", code_nib); end
    @(posedge clk);
    #1;
    n_tests++; if (code_nib !== 8'h5A) begin n_fail++; $display("FAIL latency_5clk got %h exp 5a", code_nib); end
    @(negedge clk);
    ps2_clk = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_typematic();
    test_bad_parity();
    test_bad_stop();
    test_timeout_ext();
    test_reset_midframe();
    test_latency();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
